// File: rtl/ref_mem_pkg.sv
// Shared definitions for the motion-estimation reference memory (fill and read sides).
package ref_mem_pkg;

    localparam int NUM_BANKS       = 32;
    localparam int BANKS_PER_GROUP = 4;
    localparam int ROWS_PER_BANK   = 96;
    localparam int REF_ADDR_W      = 7;
    localparam int NUM_SUB_AREAS   = 8;
    localparam int SUB_W           = $clog2(NUM_SUB_AREAS);
    localparam int ROW_SEL_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        DRAIN,
        DONE
    } rd_state_e;

    typedef struct packed {
        logic                 valid;
        logic [SUB_W-1:0]     sub;
        logic [ROW_SEL_W-1:0] row_sel;
        logic                 first8;
    } rd_tag_t;

endpackage

// File: rtl/ref_mem_rd_ctrl_if.sv
// Read-controller bus: start/stall in, bank reads and latency-aligned data tags out.
interface ref_mem_rd_ctrl_if
    import ref_mem_pkg::*;
#(
    parameter int ADDR_W = REF_ADDR_W,
    parameter int BANK_W = NUM_BANKS
);

    logic                 start;
    logic                 stall;
    logic [BANK_W-1:0]    rd_bank_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 out_valid;
    logic [SUB_W-1:0]     out_sub_area;
    logic [ROW_SEL_W-1:0] out_row_sel;
    logic                 out_first8;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, stall,
        output rd_bank_en, rd_addr, out_valid, out_sub_area, out_row_sel, out_first8, busy, done
    );

    modport slave (
        output start, stall,
        input  rd_bank_en, rd_addr, out_valid, out_sub_area, out_row_sel, out_first8, busy, done
    );

endinterface

// File: rtl/ref_mem_rd_ctrl_tag_pipe.sv
// RD_LAT-deep delay line aligning read tags with data returned by the reference memory.
module ref_rd_tag_pipe
    import ref_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    localparam int TAG_W  = $bits(rd_tag_t);
    localparam int PIPE_W = RD_LAT * TAG_W;

    logic [PIPE_W-1:0] pipe;

    // Flat vector shifted by one tag per cycle; oldest tag sits in the top slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= (pipe << TAG_W) | PIPE_W'(tag_in);
        end
    end

    assign tag_out = rd_tag_t'(pipe[PIPE_W-1 -: TAG_W]);

endmodule

// File: rtl/ref_mem_rd_ctrl.sv
// Reference-memory read controller: scans 8 sub-areas x 96 rows, one row per cycle,
// with a one-cycle gap between bank groups and latency-aligned data tags.
module ref_mem_rd_ctrl
    import ref_mem_pkg::*;
#(
    parameter int NUM_GROUPS      = ref_mem_pkg::NUM_SUB_AREAS,
    parameter int BANKS_PER_GROUP = ref_mem_pkg::BANKS_PER_GROUP,
    parameter int ROWS            = ref_mem_pkg::ROWS_PER_BANK,
    parameter int ADDR_W          = ref_mem_pkg::REF_ADDR_W,
    parameter int RD_LAT          = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ref_mem_rd_ctrl_if.master  bus
);

    localparam int BANK_W = NUM_GROUPS * BANKS_PER_GROUP;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BANK_W-1:0] GROUP0 =
        {{(BANK_W-BANKS_PER_GROUP){1'b0}}, {BANKS_PER_GROUP{1'b1}}};

    rd_state_e         state, state_n;
    logic [ADDR_W-1:0] row, row_n;
    logic [SUB_W-1:0]  sub, sub_n;
    logic [LAT_W-1:0]  lat, lat_n;

    logic [BANK_W-1:0] en_q, en_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              busy_q, done_q;
    logic              issue;
    rd_tag_t           tag_q, tag_n, tag_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            sub   <= '0;
            lat   <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            sub   <= sub_n;
            lat   <= lat_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        sub_n   = sub;
        lat_n   = lat;
        en_n    = '0;
        addr_n  = addr_q;
        issue   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = READ;
                    row_n   = '0;
                    sub_n   = '0;
                end
            end
            READ: begin
                // Address tracks the pending row even when stalled, so it holds during a stall.
                addr_n = row;
                if (!bus.stall) begin
                    issue = 1'b1;
                    en_n  = GROUP0 << (int'(sub) * BANKS_PER_GROUP);
                    if (row == ADDR_W'(ROWS - 1)) begin
                        row_n = '0;
                        if (sub == SUB_W'(NUM_GROUPS - 1)) begin
                            state_n = DRAIN;
                            lat_n   = '0;
                        end else begin
                            sub_n   = sub + SUB_W'(1);
                            state_n = GAP;
                        end
                    end else begin
                        row_n = row + ADDR_W'(1);
                    end
                end
            end
            GAP: begin
                state_n = READ;
            end
            DRAIN: begin
                if (lat == LAT_W'(RD_LAT - 1)) begin
                    state_n = DONE;
                end else begin
                    lat_n = lat + LAT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        tag_n = '0;
        if (issue) begin
            tag_n.valid   = 1'b1;
            tag_n.sub     = sub;
            tag_n.row_sel = row[ROW_SEL_W-1:0];
            tag_n.first8  = (row < ADDR_W'(8));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            addr_q <= '0;
            tag_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_n;
            addr_q <= addr_n;
            tag_q  <= tag_n;
            busy_q <= (state != IDLE);
            done_q <= (state == DONE);
        end
    end

    // tag_q is aligned with the registered read; the pipe adds the memory latency.
    ref_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_q),
        .tag_out (tag_out)
    );

    assign bus.rd_bank_en   = en_q;
    assign bus.rd_addr      = addr_q;
    assign bus.out_valid    = tag_out.valid;
    assign bus.out_sub_area = tag_out.sub;
    assign bus.out_row_sel  = tag_out.row_sel;
    assign bus.out_first8   = tag_out.first8;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_ref_mem_rd_ctrl.sv
// Bench for ref_mem_rd_ctrl: per-cycle comparison against a schedule model built from
// the scan rules, plus directed stall, gap, ignored-start and mid-scan reset cases.
module tb_ref_mem_rd_ctrl;
    import ref_mem_pkg::*;

    localparam int RD_LAT = 1;
    localparam int MAXC   = 1300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ref_mem_rd_ctrl_if #(.ADDR_W(7), .BANK_W(32)) bus ();

    ref_mem_rd_ctrl #(
        .NUM_GROUPS      (8),
        .BANKS_PER_GROUP (4),
        .ROWS            (96),
        .ADDR_W          (7),
        .RD_LAT          (RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    bit          stall_v    [MAXC];
    logic [31:0] e_en       [MAXC];
    int          e_addr     [MAXC];
    bit          e_addr_chk [MAXC];
    bit          e_valid    [MAXC];
    int          e_sub      [MAXC];
    int          e_rs       [MAXC];
    bit          e_f8       [MAXC];
    bit          e_done     [MAXC];
    bit          e_busy     [MAXC];

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_stall();
        for (int c = 0; c < MAXC; c++) stall_v[c] = 1'b0;
    endtask

    // Cycle k = the period after clock edge k; start is sampled at edge 0.
    // Each read is visible the cycle it is issued; data (and its tag) RD_LAT later.
    task automatic build_model(output int done_cyc);
        int t;
        for (int c = 0; c < MAXC; c++) begin
            e_en[c] = '0; e_addr[c] = 0; e_addr_chk[c] = 1'b0; e_valid[c] = 1'b0;
            e_sub[c] = 0; e_rs[c] = 0; e_f8[c] = 1'b0; e_done[c] = 1'b0; e_busy[c] = 1'b0;
        end
        t = 1;
        for (int s = 0; s < 8; s++) begin
            if (s > 0) t++;
            for (int r = 0; r < 96; r++) begin
                while (stall_v[t] && t < MAXC - 10) begin
                    e_addr_chk[t] = 1'b1;
                    e_addr[t] = r;
                    t++;
                end
                e_en[t] = 32'hF << (4 * s);
                e_addr_chk[t] = 1'b1;
                e_addr[t] = r;
                e_valid[t + RD_LAT] = 1'b1;
                e_sub[t + RD_LAT] = s;
                e_rs[t + RD_LAT] = r % 8;
                e_f8[t + RD_LAT] = (r < 8);
                t++;
            end
        end
        done_cyc = t + RD_LAT;
        e_done[done_cyc] = 1'b1;
        for (int c = 1; c <= done_cyc; c++) e_busy[c] = 1'b1;
    endtask

    task automatic run_scan(input int pulse_at, input int abort_at,
                            output int done_at, output int nvalid, output int ndone);
        int exp_done;
        int last;
        build_model(exp_done);
        last = (abort_at >= 0) ? abort_at : exp_done + 30;
        done_at = -1;
        nvalid = 0;
        ndone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.stall = stall_v[0];
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rd_bank_en", k, bus.rd_bank_en, e_en[k]);
            if (e_addr_chk[k]) chk("rd_addr", k, 32'(bus.rd_addr), 32'(e_addr[k]));
            chk("out_valid", k, 32'(bus.out_valid), 32'(e_valid[k]));
            chk("out_sub_area", k, 32'(bus.out_sub_area), 32'(e_sub[k]));
            chk("out_row_sel", k, 32'(bus.out_row_sel), 32'(e_rs[k]));
            chk("out_first8", k, 32'(bus.out_first8), 32'(e_f8[k]));
            chk("done", k, 32'(bus.done), 32'(e_done[k]));
            chk("busy", k, 32'(bus.busy), 32'(e_busy[k]));
            if (bus.out_valid === 1'b1) nvalid++;
            if (bus.done === 1'b1) begin
                ndone++;
                done_at = k;
            end
            bus.start = (k + 1 == pulse_at);
            bus.stall = (k + 1 < MAXC) ? stall_v[k + 1] : 1'b0;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag, input int cyc);
        chk({tag, "_en"}, cyc, bus.rd_bank_en, 32'h0);
        chk({tag, "_addr"}, cyc, 32'(bus.rd_addr), 32'h0);
        chk({tag, "_valid"}, cyc, 32'(bus.out_valid), 32'h0);
        chk({tag, "_sub"}, cyc, 32'(bus.out_sub_area), 32'h0);
        chk({tag, "_rowsel"}, cyc, 32'(bus.out_row_sel), 32'h0);
        chk({tag, "_first8"}, cyc, 32'(bus.out_first8), 32'h0);
        chk({tag, "_busy"}, cyc, 32'(bus.busy), 32'h0);
        chk({tag, "_done"}, cyc, 32'(bus.done), 32'h0);
    endtask

    int d, nv, nd;

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unstalled scan: reads 1..775, done at 777, 768 data beats.
        clear_stall();
        run_scan(-1, -1, d, nv, nd);
        chk("a_done_cycle", 0, d, 777);
        chk("a_valid_count", 0, nv, 768);
        chk("a_done_pulses", 0, nd, 1);

        // Five stalled cycles while row 40 of sub-area 0 is pending.
        clear_stall();
        for (int c = 41; c <= 45; c++) stall_v[c] = 1'b1;
        run_scan(-1, -1, d, nv, nd);
        chk("c_done_cycle", 0, d, 782);
        chk("c_valid_count", 0, nv, 768);

        // Stall across the first GAP (edge 97) plus start pulse mid-scan.
        clear_stall();
        for (int c = 97; c <= 99; c++) stall_v[c] = 1'b1;
        run_scan(300, -1, d, nv, nd);
        chk("d_done_cycle", 0, d, 779);
        chk("d_done_pulses", 0, nd, 1);

        // Random stalls with an ignored start pulse.
        clear_stall();
        for (int c = 1; c < 900; c++) stall_v[c] = ($urandom_range(0, 7) == 0);
        run_scan(300, -1, d, nv, nd);
        chk("b_valid_count", 0, nv, 768);
        chk("b_done_pulses", 0, nd, 1);

        // Reset while row 50 of sub-area 3 is on the bus.
        clear_stall();
        run_scan(-1, 342, d, nv, nd);
        chk("e_en_before_reset", 342, bus.rd_bank_en, 32'h0000_F000);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset", 342);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_reset_valid", k, 32'(bus.out_valid), 32'h0);
            chk("post_reset_busy", k, 32'(bus.busy), 32'h0);
            chk("post_reset_en", k, bus.rd_bank_en, 32'h0);
        end

        // Fresh scan after reset starts from group 0, row 0.
        clear_stall();
        run_scan(-1, -1, d, nv, nd);
        chk("f_done_cycle", 0, d, 777);
        chk("f_valid_count", 0, nv, 768);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
